// File: rtl/freq_pkg.sv
// Shared types and defaults for the frequency-meter display register.
`default_nettype none

package freq_pkg;

    typedef enum logic [1:0] {
        NORMAL    = 2'd0,
        MAX_HOLD  = 2'd1,
        MIN_HOLD  = 2'd2,
        RESERVADO = 2'd3
    } modo_t;

    localparam int BCD_MAX       = 9;
    localparam int N_DIGITOS_DEF = 5;
    localparam int LARGURA_DEF   = 4;

endpackage

`default_nettype wire

// File: rtl/sincronizador_borda.sv
//==============================================================================
// Module      : sincronizador_borda
// Description : Multi-stage synchroniser followed by a rising-edge detector.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module sincronizador_borda #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic assinc_in,
    output logic pulso_out
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], assinc_in};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    // High for exactly one cycle per synchronised low-to-high transition.
    assign pulso_out = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule

`default_nettype wire

// File: rtl/registrador_leitura_param.sv
//==============================================================================
// Module      : registrador_leitura_param
// Description : Held BCD display register with peak/valley hold, freeze,
//               BCD validation, leading-zero blanking and an update pulse.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module registrador_leitura_param
    import freq_pkg::*;
#(
    parameter int N_DIGITOS   = N_DIGITOS_DEF,
    parameter int LARGURA     = LARGURA_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           armazena,
    input  logic                           limpar,
    input  logic                           congelar,
    input  logic [1:0]                     modo,
    input  logic [N_DIGITOS*LARGURA-1:0]   digitos_in,
    output logic [N_DIGITOS*LARGURA-1:0]   digitos_out,
    output logic [N_DIGITOS-1:0]           brancos_out,
    output logic                           atualizado,
    output logic                           erro_bcd
);

    localparam int                   c_W            = N_DIGITOS * LARGURA;
    localparam logic [LARGURA-1:0]   c_BCD_MAX_DIG  = LARGURA'(BCD_MAX);
    localparam logic [N_DIGITOS-1:0] c_BRANCOS_RST  = {{(N_DIGITOS-1){1'b1}}, 1'b0};

    logic             w_evt_armazena;
    logic             w_evt_limpar;
    logic             w_bcd_invalido;
    logic             w_zeros_acima;
    logic [N_DIGITOS-1:0] w_brancos_in;
    logic             w_aceita;

    logic [c_W-1:0]       r_digitos;
    logic [N_DIGITOS-1:0] r_brancos;
    logic                 r_atualizado;
    logic                 r_erro_bcd;
    logic                 r_vazio;

    sincronizador_borda #(.SYNC_STAGES(SYNC_STAGES)) u_sinc_armazena (
        .clk       (clk),
        .rst_n     (rst_n),
        .assinc_in (armazena),
        .pulso_out (w_evt_armazena)
    );

    sincronizador_borda #(.SYNC_STAGES(SYNC_STAGES)) u_sinc_limpar (
        .clk       (clk),
        .rst_n     (rst_n),
        .assinc_in (limpar),
        .pulso_out (w_evt_limpar)
    );

    // Walk from the MSD down so each blanking bit sees all higher digits.
    always_comb begin
        w_bcd_invalido = 1'b0;
        w_zeros_acima  = 1'b1;
        w_brancos_in   = '0;
        for (int i = N_DIGITOS - 1; i >= 0; i--) begin
            if (digitos_in[i*LARGURA +: LARGURA] > c_BCD_MAX_DIG)
                w_bcd_invalido = 1'b1;
            w_zeros_acima = w_zeros_acima & (digitos_in[i*LARGURA +: LARGURA] == '0);
            if (i > 0)
                w_brancos_in[i] = w_zeros_acima;
        end
    end

    always_comb begin
        w_aceita = 1'b1;
        case (modo_t'(modo))
            MAX_HOLD: w_aceita = r_vazio | (digitos_in > r_digitos);
            MIN_HOLD: w_aceita = r_vazio | (digitos_in < r_digitos);
            default:  w_aceita = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_digitos    <= '0;
            r_brancos    <= c_BRANCOS_RST;
            r_atualizado <= 1'b0;
            r_erro_bcd   <= 1'b0;
            r_vazio      <= 1'b1;
        end else if (w_evt_limpar) begin
            r_digitos    <= '0;
            r_brancos    <= c_BRANCOS_RST;
            r_atualizado <= 1'b0;
            r_erro_bcd   <= 1'b0;
            r_vazio      <= 1'b1;
        end else if (w_evt_armazena && !congelar) begin
            if (w_bcd_invalido) begin
                r_erro_bcd   <= 1'b1;
                r_atualizado <= 1'b0;
            end else if (w_aceita) begin
                r_digitos    <= digitos_in;
                r_brancos    <= w_brancos_in;
                r_vazio      <= 1'b0;
                r_atualizado <= 1'b1;
            end else begin
                r_atualizado <= 1'b0;
            end
        end else begin
            r_atualizado <= 1'b0;
        end
    end

    assign digitos_out = r_digitos;
    assign brancos_out = r_brancos;
    assign atualizado  = r_atualizado;
    assign erro_bcd    = r_erro_bcd;

endmodule

`default_nettype wire

// File: tb/tb_registrador_leitura_param.sv
//==============================================================================
// Module      : tb_registrador_leitura_param
// Description : Directed self-checking bench for registrador_leitura_param.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_registrador_leitura_param;

    logic        clk;
    logic        rst_n;
    logic        armazena;
    logic        limpar;
    logic        congelar;
    logic [1:0]  modo;
    logic [19:0] digitos_in;
    logic [19:0] digitos_out;
    logic [4:0]  brancos_out;
    logic        atualizado;
    logic        erro_bcd;

    int n_checks = 0;
    int n_fail   = 0;
    int n_pulsos = 0;
    int p0;

    registrador_leitura_param dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .armazena    (armazena),
        .limpar      (limpar),
        .congelar    (congelar),
        .modo        (modo),
        .digitos_in  (digitos_in),
        .digitos_out (digitos_out),
        .brancos_out (brancos_out),
        .atualizado  (atualizado),
        .erro_bcd    (erro_bcd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (atualizado) n_pulsos++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic pulso(input logic st, input logic cl, input logic [19:0] v);
        digitos_in = v;
        @(negedge clk);
        armazena = st;
        limpar   = cl;
        repeat (4) @(negedge clk);
        armazena = 1'b0;
        limpar   = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; armazena = 1'b0; limpar = 1'b0; congelar = 1'b0;
        modo = 2'd0; digitos_in = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_dig",  digitos_out, 20'h0);
        chk("rst_bra",  brancos_out, 5'b11110);
        chk("rst_atu",  atualizado, 1'b0);
        chk("rst_err",  erro_bcd, 1'b0);

        // NORMAL store with latency check
        digitos_in = 20'h01234;
        p0 = n_pulsos;
        @(negedge clk);
        armazena = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        chk("lat_edge2", digitos_out, 20'h0);
        @(posedge clk); #1;
        chk("lat_edge3", digitos_out, 20'h01234);
        chk("lat_atu",   atualizado, 1'b1);
        chk("lat_bra",   brancos_out, 5'b10000);
        @(negedge clk); @(negedge clk);
        armazena = 1'b0;
        repeat (4) @(negedge clk);
        chk("norm_npul", n_pulsos - p0, 1);

        // MAX_HOLD
        pulso(1'b0, 1'b1, 20'h0);
        chk("clr_dig", digitos_out, 20'h0);
        modo = 2'd1;
        p0 = n_pulsos; pulso(1'b1, 1'b0, 20'h00500);
        chk("max1", digitos_out, 20'h00500); chk("max1_p", n_pulsos - p0, 1);
        chk("max1_bra", brancos_out, 5'b11000);
        p0 = n_pulsos; pulso(1'b1, 1'b0, 20'h00300);
        chk("max2", digitos_out, 20'h00500); chk("max2_p", n_pulsos - p0, 0);
        p0 = n_pulsos; pulso(1'b1, 1'b0, 20'h00700);
        chk("max3", digitos_out, 20'h00700); chk("max3_p", n_pulsos - p0, 1);
        p0 = n_pulsos; pulso(1'b1, 1'b0, 20'h00700);
        chk("max4", digitos_out, 20'h00700); chk("max4_p", n_pulsos - p0, 0);

        // MIN_HOLD after clear
        pulso(1'b0, 1'b1, 20'h0);
        modo = 2'd2;
        pulso(1'b1, 1'b0, 20'h00900);
        chk("min1", digitos_out, 20'h00900);
        pulso(1'b1, 1'b0, 20'h00400);
        chk("min2", digitos_out, 20'h00400);
        pulso(1'b1, 1'b0, 20'h00600);
        chk("min3", digitos_out, 20'h00400);

        // Simultaneous store and clear: clear wins
        modo = 2'd0;
        p0 = n_pulsos; pulso(1'b1, 1'b1, 20'h00999);
        chk("sim_dig", digitos_out, 20'h0);
        chk("sim_p",   n_pulsos - p0, 0);
        chk("sim_bra", brancos_out, 5'b11110);

        // Freeze
        congelar = 1'b1;
        p0 = n_pulsos; pulso(1'b1, 1'b0, 20'h12345);
        chk("frz_dig", digitos_out, 20'h0);
        chk("frz_p",   n_pulsos - p0, 0);
        congelar = 1'b0;

        // Reserved mode acts as NORMAL
        modo = 2'd3;
        pulso(1'b1, 1'b0, 20'h00042);
        chk("res_dig", digitos_out, 20'h00042);
        chk("res_bra", brancos_out, 5'b11100);
        modo = 2'd0;

        // Invalid digit
        p0 = n_pulsos; pulso(1'b1, 1'b0, 20'h00A42);
        chk("inv_dig", digitos_out, 20'h00042);
        chk("inv_err", erro_bcd, 1'b1);
        chk("inv_p",   n_pulsos - p0, 0);
        pulso(1'b1, 1'b0, 20'h00077);
        chk("inv_dig2", digitos_out, 20'h00077);
        chk("inv_err2", erro_bcd, 1'b1);
        pulso(1'b0, 1'b1, 20'h0);
        chk("clr_err", erro_bcd, 1'b0);
        chk("clr_dig2", digitos_out, 20'h0);

        // Reset during synchronisation discards the strobe
        digitos_in = 20'h00555;
        p0 = n_pulsos;
        @(negedge clk);
        armazena = 1'b1;
        @(posedge clk); #2;
        rst_n    = 1'b0;
        armazena = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("rstm_dig", digitos_out, 20'h0);
        chk("rstm_p",   n_pulsos - p0, 0);
        chk("rstm_bra", brancos_out, 5'b11110);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
